// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB bridge master.
//   - apb_state_e : bridge FSM states (idle, setup, access, error response)
//   - APB_AW/APB_DW : APB register address / data widths
//   - SLV_IDX_LSB/SLV_IDX_W : location of the slave index inside a request address
//   - slv_idx() : pulls the slave index out of a 32-bit request address
package apb_pkg;

    localparam int unsigned APB_AW      = 8;
    localparam int unsigned APB_DW      = 8;
    localparam int unsigned SLV_IDX_LSB = 12;
    localparam int unsigned SLV_IDX_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StErr
    } apb_state_e;

    function automatic logic [SLV_IDX_W-1:0] slv_idx(input logic [31:0] addr);
        return addr[SLV_IDX_LSB +: SLV_IDX_W];
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: combinational request-address decoder.
// An address is mapped when addr[31:16] equals BASE and the slave index
// addr[15:12] is below NSLV; the matching slave gets a one-hot select.
// Ports:
//   addr   in  32    request byte address
//   sel    out NSLV  one-hot slave select (all zero when unmapped)
//   mapped out 1     address hits an existing slave
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int unsigned NSLV = 4,
    parameter logic [15:0] BASE = 16'h1FD0
) (
    input  logic [31:0]     addr,
    output logic [NSLV-1:0] sel,
    output logic            mapped
);

    logic [SLV_IDX_W-1:0] idx;
    logic                 base_hit;
    logic                 idx_hit;
    logic                 unused_addr;

    assign idx      = slv_idx(addr);
    assign base_hit = (addr[31:16] == BASE);
    assign idx_hit  = (32'(idx) < NSLV);
    assign mapped   = base_hit & idx_hit;
    assign sel      = mapped ? (NSLV'(1) << idx) : '0;

    // Register offset bits play no part in slave selection.
    assign unused_addr = ^addr[SLV_IDX_LSB-1:0];

endmodule

// File: rtl/apb_bridge_master.sv
// apb_bridge_master: request/response to APB initiator.
// Accepts one request in IDLE, runs SETUP then ACCESS on the selected slave
// and returns a registered one-cycle response. Unmapped addresses skip the
// APB cycle and get an error response one cycle after acceptance.
// Optional build macro APB_PREADY_EN: adds the apb_ready port; ACCESS then
// waits for the selected slave's ready, with a TIMEOUT-cycle error bailout.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_wr/req_addr/req_wdata request direction, address, write data
//   resp_valid/resp_rdata/resp_err one-cycle response pulse
//   apb_sel/apb_en/apb_addr/apb_wen/apb_wdata  APB initiator outputs
//   apb_rdata                per-slave read data, slave i at [8i+7:8i]
//   apb_ready                per-slave ready (APB_PREADY_EN only)
module apb_bridge_master
    import apb_pkg::*;
#(
    parameter int unsigned NSLV    = 4,
    parameter logic [15:0] BASE    = 16'h1FD0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [31:0]            req_addr,
    input  logic [APB_DW-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [APB_DW-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic [NSLV-1:0]        apb_sel,
    output logic                   apb_en,
    output logic [APB_AW-1:0]      apb_addr,
    output logic                   apb_wen,
    output logic [APB_DW-1:0]      apb_wdata,
    input  logic [APB_DW*NSLV-1:0] apb_rdata
`ifdef APB_PREADY_EN
    ,
    input  logic [NSLV-1:0]        apb_ready
`endif
);

    apb_state_e        state_q, state_d;
    logic [NSLV-1:0]   sel_q, sel_d;
    logic              wr_q, wr_d;
    logic [APB_AW-1:0] addr_q, addr_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [APB_DW-1:0] resp_rdata_q, resp_rdata_d;

    logic [NSLV-1:0]   dec_sel;
    logic              dec_mapped;
    logic [APB_DW-1:0] rdata_mux;
    logic              in_xfer;

`ifdef APB_PREADY_EN
    logic [7:0] wait_q, wait_d;
    logic [7:0] wait_inc;
    logic       slv_ready;

    assign slv_ready = |(apb_ready & sel_q);
    assign wait_inc  = wait_q + 8'd1;
`else
    logic unused_cfg;
    assign unused_cfg = ^32'(TIMEOUT);
`endif

    apb_addr_decode #(
        .NSLV (NSLV),
        .BASE (BASE)
    ) u_decode (
        .addr   (req_addr),
        .sel    (dec_sel),
        .mapped (dec_mapped)
    );

    // AND-OR mux keyed by the latched one-hot select.
    always_comb begin
        rdata_mux = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            rdata_mux = rdata_mux | (apb_rdata[i*APB_DW +: APB_DW] & {APB_DW{sel_q[i]}});
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
`ifdef APB_PREADY_EN
        wait_d       = wait_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (dec_mapped) begin
                        // APB-side registers only move on real transfers, so
                        // they keep the last transfer's values across errors.
                        sel_d   = dec_sel;
                        wr_d    = req_wr;
                        addr_d  = req_addr[APB_AW-1:0];
                        wdata_d = req_wdata;
                        state_d = StSetup;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
`ifdef APB_PREADY_EN
                wait_d  = '0;
`endif
            end
            StAccess: begin
`ifdef APB_PREADY_EN
                if (slv_ready) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wr_q ? '0 : rdata_mux;
                    state_d      = StIdle;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc >= 8'(TIMEOUT)) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = StIdle;
                    end
                end
`else
                resp_valid_d = 1'b1;
                resp_rdata_d = wr_q ? '0 : rdata_mux;
                state_d      = StIdle;
`endif
            end
            StErr: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

`ifdef APB_PREADY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    // Select/enable decode straight from the state register so an async
    // reset drops them without waiting for a clock edge.
    assign in_xfer    = (state_q == StSetup) || (state_q == StAccess);
    assign req_ready  = (state_q == StIdle);
    assign apb_sel    = in_xfer ? sel_q : '0;
    assign apb_en     = (state_q == StAccess);
    assign apb_wen    = in_xfer & wr_q;
    assign apb_addr   = addr_q;
    assign apb_wdata  = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_apb_bridge_master.sv
// tb_apb_bridge_master: directed bench for apb_bridge_master (NSLV=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_apb_bridge_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_err;
    logic [3:0]  apb_sel;
    logic        apb_en;
    logic [7:0]  apb_addr;
    logic        apb_wen;
    logic [7:0]  apb_wdata;
    logic [31:0] apb_rdata;
`ifdef APB_PREADY_EN
    logic [3:0]  apb_ready;
    assign apb_ready = 4'hF;
`endif

    int n_chk;
    int n_fail;

    apb_bridge_master #(
        .NSLV    (4),
        .BASE    (16'h1FD0),
        .TIMEOUT (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .apb_sel    (apb_sel),
        .apb_en     (apb_en),
        .apb_addr   (apb_addr),
        .apb_wen    (apb_wen),
        .apb_wdata  (apb_wdata),
        .apb_rdata  (apb_rdata)
`ifdef APB_PREADY_EN
        ,
        .apb_ready  (apb_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] b2b_addr [3];
        logic [7:0]  b2b_exp  [3];
        logic [3:0]  b2b_sel  [3];
        logic [31:0] bad_addr [2];

        n_chk  = 0;
        n_fail = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        // slave3=33 slave2=22 slave1=A5 slave0=11
        apb_rdata = 32'h3322_A511;

        // ---------------- reset state
        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_sel", apb_sel, 0);
        chk("rst_en", apb_en, 0);
        chk("rst_wen", apb_wen, 0);
        chk("rst_addr", apb_addr, 0);
        chk("rst_wdata", apb_wdata, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // ---------------- read slave 1 @ 0x1FD01000
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h1FD0_1000;
        chk("rd_T_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("rd_T1_sel", apb_sel, 4'b0010);
        chk("rd_T1_en", apb_en, 0);
        chk("rd_T1_wen", apb_wen, 0);
        chk("rd_T1_ready", req_ready, 0);
        tick();
        chk("rd_T2_sel", apb_sel, 4'b0010);
        chk("rd_T2_en", apb_en, 1);
        chk("rd_T2_rvalid", resp_valid, 0);
        tick();
        chk("rd_T3_rvalid", resp_valid, 1);
        chk("rd_T3_rdata", resp_rdata, 8'hA5);
        chk("rd_T3_err", resp_err, 0);
        chk("rd_T3_sel", apb_sel, 0);
        chk("rd_T3_en", apb_en, 0);
        chk("rd_T3_ready", req_ready, 1);
        tick();
        chk("rd_T4_rvalid", resp_valid, 0);

        // ---------------- write 0x41 to slave 0 reg 0x00
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 32'h1FD0_0000;
        req_wdata = 8'h41;
        tick();
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_wdata = 8'h00;
        chk("wr_T1_sel", apb_sel, 4'b0001);
        chk("wr_T1_en", apb_en, 0);
        chk("wr_T1_wen", apb_wen, 1);
        chk("wr_T1_wdata", apb_wdata, 8'h41);
        chk("wr_T1_addr", apb_addr, 8'h00);
        tick();
        chk("wr_T2_en", apb_en, 1);
        chk("wr_T2_wen", apb_wen, 1);
        chk("wr_T2_wdata", apb_wdata, 8'h41);
        tick();
        chk("wr_T3_en", apb_en, 0);
        chk("wr_T3_wen", apb_wen, 0);
        chk("wr_T3_rvalid", resp_valid, 1);
        chk("wr_T3_rdata", resp_rdata, 0);
        chk("wr_T3_err", resp_err, 0);
        tick();

        // ---------------- unmapped: index 7 >= NSLV, and wrong base
        bad_addr[0] = 32'h1FD0_7000;
        bad_addr[1] = 32'h2000_0000;
        for (int k = 0; k < 2; k++) begin
            req_valid = 1'b1;
            req_addr  = bad_addr[k];
            chk("err_T_ready", req_ready, 1);
            tick();
            req_valid = 1'b0;
            chk("err_T1_sel", apb_sel, 0);
            chk("err_T1_en", apb_en, 0);
            chk("err_T1_rvalid", resp_valid, 0);
            chk("err_T1_ready", req_ready, 0);
            tick();
            chk("err_T2_rvalid", resp_valid, 1);
            chk("err_T2_err", resp_err, 1);
            chk("err_T2_rdata", resp_rdata, 0);
            chk("err_T2_sel", apb_sel, 0);
            chk("err_T2_ready", req_ready, 1);
            // Error path leaves the APB address/data from the last transfer.
            chk("err_T2_apbaddr", apb_addr, 8'h00);
            chk("err_T2_apbwdata", apb_wdata, 8'h41);
            tick();
            chk("err_T3_rvalid", resp_valid, 0);
        end

        // ---------------- back-to-back reads with req_valid held
        b2b_addr[0] = 32'h1FD0_2010; b2b_exp[0] = 8'h22; b2b_sel[0] = 4'b0100;
        b2b_addr[1] = 32'h1FD0_3020; b2b_exp[1] = 8'h33; b2b_sel[1] = 4'b1000;
        b2b_addr[2] = 32'h1FD0_0030; b2b_exp[2] = 8'h11; b2b_sel[2] = 4'b0001;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = b2b_addr[0];
        for (int k = 0; k < 3; k++) begin
            chk("b2b_accept_ready", req_ready, 1);
            tick();
            chk("b2b_T1_ready", req_ready, 0);
            chk("b2b_T1_sel", apb_sel, b2b_sel[k]);
            chk("b2b_T1_addr", apb_addr, b2b_addr[k][7:0]);
            chk("b2b_T1_rvalid", resp_valid, 0);
            tick();
            chk("b2b_T2_ready", req_ready, 0);
            chk("b2b_T2_en", apb_en, 1);
            chk("b2b_T2_rvalid", resp_valid, 0);
            tick();
            chk("b2b_T3_rvalid", resp_valid, 1);
            chk("b2b_T3_rdata", resp_rdata, b2b_exp[k]);
            chk("b2b_T3_err", resp_err, 0);
            if (k < 2) begin
                req_addr = b2b_addr[k+1];
            end else begin
                req_valid = 1'b0;
            end
        end
        tick();
        chk("b2b_end_rvalid", resp_valid, 0);
        chk("b2b_end_ready", req_ready, 1);

        // ---------------- reset asserted during ACCESS
        req_valid = 1'b1;
        req_addr  = 32'h1FD0_1000;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstmid_pre_en", apb_en, 1);
        chk("rstmid_pre_sel", apb_sel, 4'b0010);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_async_sel", apb_sel, 0);
        chk("rstmid_async_en", apb_en, 0);
        chk("rstmid_async_rvalid", resp_valid, 0);
        tick();
        chk("rstmid_hold_rvalid", resp_valid, 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rstmid_post_rvalid", resp_valid, 0);
            chk("rstmid_post_ready", req_ready, 1);
            chk("rstmid_post_sel", apb_sel, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
